// File: rtl/apb_cfg_loader_if.sv
// APB bus bundle between the configuration loader (master) and the register slave.
interface apb_cfg_loader_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [3:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_cfg_loader.sv
// Loads six region-table values over APB (write pass, optional read-back pass),
// with wait-state timeout and error capture.
//
// state  | meaning
// IDLE   | no activity, waiting for start
// SETUP  | APB setup phase of the current transfer (one cycle)
// ACCESS | APB access phase, waiting for PREADY
// DONE   | sequence finished or aborted, status held until next start
module apb_cfg_loader #(
  parameter int VERIFY  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        cfg_wtable_m0,
  input  logic [2:0]        cfg_wtable_m1,
  input  logic [2:0]        cfg_wtable_m2,
  input  logic [2:0]        cfg_rtable_m0,
  input  logic [2:0]        cfg_rtable_m1,
  input  logic [2:0]        cfg_rtable_m2,
  apb_cfg_loader_if.master  apb,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [3:0]        err_addr,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  localparam bit         HAS_VERIFY = (VERIFY != 0);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        pass_q, pass_d;
  logic [7:0]  wait_q, wait_d;
  logic [17:0] snap_q, snap_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [3:0]  paddr_q, paddr_d;
  logic [7:0]  pwdata_q, pwdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  err_addr_q, err_addr_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        fin;
  logic [1:0]  fin_code;
  logic        last_xfer;
  logic [2:0]  nidx;
  logic        npass;
  logic [7:0]  rd_exp;

  // Snapshot layout: {rtable_m2, rtable_m1, rtable_m0, wtable_m2, wtable_m1, wtable_m0}
  function automatic logic [2:0] pick(input logic [2:0] idx, input logic [17:0] s);
    case (idx)
      3'd0:    pick = s[2:0];
      3'd1:    pick = s[5:3];
      3'd2:    pick = s[8:6];
      3'd3:    pick = s[11:9];
      3'd4:    pick = s[14:12];
      3'd5:    pick = s[17:15];
      default: pick = 3'd0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    wait_d     = wait_q;
    snap_d     = snap_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    err_code_d = err_code_q;
    fin        = 1'b0;
    fin_code   = 2'b00;
    rd_exp     = {5'b0, pick(idx_q, snap_q)};
    last_xfer  = (idx_q == 3'd5) && (pass_q || !HAS_VERIFY);
    nidx       = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    npass      = (idx_q == 3'd5) ? 1'b1 : pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          snap_d     = {cfg_rtable_m2, cfg_rtable_m1, cfg_rtable_m0,
                        cfg_wtable_m2, cfg_wtable_m1, cfg_wtable_m0};
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_addr_d = 4'd0;
          err_code_d = 2'b00;
          idx_d      = 3'd0;
          pass_d     = 1'b0;
          wait_d     = 8'd0;
          state_d    = S_SETUP;
          busy_d     = 1'b1;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = 1'b1;
          paddr_d    = 4'd0;
          // Snapshot is not in snap_q yet, so the first write takes the live input.
          pwdata_d   = {5'b0, cfg_wtable_m0};
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (apb.PREADY) begin
          if (apb.PSLVERR) begin
            fin      = 1'b1;
            fin_code = 2'b01;
          end else if (pass_q && (apb.PRDATA != rd_exp)) begin
            fin      = 1'b1;
            fin_code = 2'b10;
          end else if (last_xfer) begin
            fin      = 1'b1;
          end else begin
            state_d   = S_SETUP;
            penable_d = 1'b0;
            idx_d     = nidx;
            pass_d    = npass;
            wait_d    = 8'd0;
            paddr_d   = {1'b0, nidx};
            pwrite_d  = !npass;
            pwdata_d  = npass ? 8'd0 : {5'b0, pick(nidx, snap_q)};
          end
        end else if (wait_q == WAIT_LAST) begin
          fin      = 1'b1;
          fin_code = 2'b11;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d    = S_DONE;
      psel_d     = 1'b0;
      penable_d  = 1'b0;
      pwrite_d   = 1'b0;
      paddr_d    = 4'd0;
      pwdata_d   = 8'd0;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      error_d    = (fin_code != 2'b00);
      err_addr_d = paddr_q;
      err_code_d = fin_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      pass_q     <= 1'b0;
      wait_q     <= 8'd0;
      snap_q     <= 18'd0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 4'd0;
      pwdata_q   <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= 4'd0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      wait_q     <= wait_d;
      snap_q     <= snap_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      err_code_q <= err_code_d;
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_addr    = err_addr_q;
  assign err_code    = err_code_q;

endmodule

// File: doc/apb_cfg_loader.md
APB_CFG_LOADER -- requirements
Module: apb_cfg_loader

Interface
REQ-001 Parameter: VERIFY, 1, nonzero enables read-back compare pass after write pass.
REQ-002 Parameter: TIMEOUT, 15, maximum ACCESS-phase cycles waiting for PREADY before abort (1..255).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one load sequence; sampled only in IDLE or DONE.
REQ-006 cfg_wtable_m0/m1/m2  input  3 each  write-region table values for masters 0..2.
REQ-007 cfg_rtable_m0/m1/m2  input  3 each  read-region table values for masters 0..2.
REQ-008 PSEL, PENABLE, PWRITE  output  1 each  APB master controls.
REQ-009 PADDR  output  4  APB address; PWDATA  output  8  APB write data.
REQ-010 PRDATA  input  8; PREADY  input  1; PSLVERR  input  1  APB slave responses.
REQ-011 busy  output  1  sequence in progress; done  output  1  sequence finished (level).
REQ-012 error  output  1  sequence aborted; err_addr  output  4  PADDR of failing transfer; err_code  output  2  cause.

Function
REQ-013 States: IDLE, SETUP, ACCESS, DONE; single FSM.
REQ-014 start=1 in IDLE or DONE snapshots all six cfg inputs into internal registers, clears done/error/err_addr/err_code, sets index=0, pass=WRITE, enters SETUP next cycle.
REQ-015 cfg input changes after the snapshot edge do not affect the running sequence.
REQ-016 Transfer order: write pass PADDR 0..5 = wtable_m0, m1, m2, rtable_m0, m1, m2; PWDATA = {5'b0, value}, PWRITE=1.
REQ-017 If VERIFY!=0, read pass follows: PADDR 0..5 same order, PWRITE=0, PWDATA=0.
REQ-018 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid; always exactly one cycle; then ACCESS.
REQ-019 ACCESS: PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA held stable until PREADY=1.
REQ-020 Transfer completes on an ACCESS cycle with PREADY=1; PSLVERR and PRDATA are sampled only then.
REQ-021 On clean completion with more transfers pending: next transfer SETUP in the following cycle (no idle gap; PSEL stays 1, PENABLE drops to 0).
REQ-022 With zero wait states each transfer takes 2 cycles; full sequence with VERIFY=1 = 24 cycles from first SETUP to DONE entry; VERIFY=0 = 12 cycles.
REQ-023 After the last transfer completes cleanly: DONE next cycle, done=1, error=0.
REQ-024 Wait-state counter cleared on SETUP entry, incremented per ACCESS cycle with PREADY=0; when it reaches TIMEOUT with PREADY still 0, abort.
REQ-025 Abort causes, err_code: 01 = PSLVERR on completion, 10 = read mismatch (PRDATA != {5'b0, snapshot value}), 11 = timeout; 00 = no error.
REQ-026 On abort: DONE next cycle, done=1, error=1, err_addr=PADDR of failing transfer, err_code set; no further transfers issued.
REQ-027 PSLVERR=1 on a read completion takes priority over mismatch (err_code=01).
REQ-028 busy=1 in SETUP and ACCESS, else 0; PSEL=0 and PENABLE=0 in IDLE and DONE.
REQ-029 start while busy=1 is ignored; start in DONE restarts the sequence (REQ-014).
REQ-030 done, error, err_addr, err_code hold their values in DONE until next start or reset.
REQ-031 PADDR/PWDATA/PWRITE drive 0 when PSEL=0.

Reset
REQ-032 rst_n=0 forces IDLE immediately, regardless of the current state, including mid-transfer.
REQ-033 Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, busy=0, done=0, error=0, err_addr=0, err_code=00, wait counter=0, index=0, snapshots=0.
REQ-034 After reset release, no APB activity occurs until start=1.

Verification
REQ-035 VERIFY=1, PREADY=1, wtable={1,2,3}, rtable={4,5,6}, slave echoes -> writes 0x01,0x02,0x03,0x04,0x05,0x06 to addr 0..5, 6 reads, done=1 and error=0 after 24 cycles.
REQ-036 Slave inserts 3 wait states on addr 2 -> ACCESS held 4 cycles with stable PADDR=2, sequence completes with error=0 in 27 cycles.
REQ-037 PSLVERR=1 on write to addr 4 -> done=1, error=1, err_addr=4, err_code=01, no transfer to addr 5.
REQ-038 Read of addr 1 returns 0x07 when expected 0x02 -> error=1, err_addr=1, err_code=10.
REQ-039 PREADY held 0 on addr 0 with TIMEOUT=15 -> abort after 15 wait cycles, err_addr=0, err_code=11; start pulse while busy earlier ignored.
REQ-040 rst_n asserted during ACCESS of addr 3 -> PSEL/PENABLE=0 at once, all outputs at reset values; new start reruns full sequence from addr 0.
